// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch-to-decode bundle and datapath widths.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush.
// Head entry reads as zero while empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  count_n;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rptr];

  always_comb begin
    count_n = count;
    unique case (1'b1)
      flush:                  count_n = '0;
      !flush && push && !pop: count_n = count + CW'(1);
      !flush && pop && !push: count_n = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count_n;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // Storage needs no reset: it is never visible while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem drive, fetch queue.
// Redirect flushes the queue and reloads the word-aligned PC.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [31:0]               imem_data,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [XLEN-1:0]           id_pc,
  output logic [31:0]               id_instr,
  output logic [$clog2(QDEPTH):0]   q_count
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_n;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  fetch_entry_t    wdata;
  fetch_entry_t    rdata;

  assign imem_addr = pc_q;
  assign id_valid  = !empty;
  assign pop       = id_valid && id_ready;
  assign push      = !redirect_valid && (!full || pop);
  assign wdata     = '{pc: pc_q, instr: imem_data};
  assign id_pc     = rdata.pc;
  assign id_instr  = rdata.instr;

  always_comb begin
    pc_n = pc_q;
    unique case (1'b1)
      redirect_valid: pc_n = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      push:           pc_n = pc_q + XLEN'(INSTR_BYTES);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_n;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .count   (q_count),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
// Second instance exercises PC wrap from a top-of-space reset PC.
module tb_fetch_stage;
  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        rst0;
  logic [31:0] addr0;
  logic [31:0] data0;
  logic        rv0;
  logic [31:0] rpc0;
  logic        v0;
  logic        rdy0;
  logic [31:0] pc0;
  logic [31:0] ins0;
  logic [1:0]  cnt0;

  logic        rst1;
  logic [31:0] addr1;
  logic [31:0] data1;
  logic        rv1;
  logic [31:0] rpc1;
  logic        v1;
  logic        rdy1;
  logic [31:0] pc1;
  logic [31:0] ins1;
  logic [1:0]  cnt1;

  always #10 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h13;
  endfunction

  assign data0 = instr_of(addr0);
  assign data1 = instr_of(addr1);

  fetch_stage #(.RESET_PC(32'h0), .QDEPTH(2)) u0 (
    .clk(clk), .reset_n(rst0), .imem_addr(addr0), .imem_data(data0),
    .redirect_valid(rv0), .redirect_pc(rpc0), .id_valid(v0),
    .id_ready(rdy0), .id_pc(pc0), .id_instr(ins0), .q_count(cnt0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) u1 (
    .clk(clk), .reset_n(rst1), .imem_addr(addr1), .imem_data(data1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .id_valid(v1),
    .id_ready(rdy1), .id_pc(pc1), .id_instr(ins1), .q_count(cnt1)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b0; rv0 = 1'b0; rpc0 = '0; rdy0 = 1'b0;
    rst1 = 1'b0; rv1 = 1'b0; rpc1 = '0; rdy1 = 1'b1;

    // reset state
    #5;
    check("rst_addr", addr0, 32'h0);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_idpc", pc0, 32'h0);
    check("rst_instr", ins0, 32'h0);
    @(negedge clk);
    rst0 = 1'b1;

    // first instruction one edge after release
    @(negedge clk);
    check("first_valid", 32'(v0), 32'd1);
    check("first_pc", pc0, 32'h0);
    check("first_instr", ins0, instr_of(32'h0));
    check("first_count", 32'(cnt0), 32'd1);
    check("first_addr", addr0, 32'h4);
    rdy0 = 1'b1;

    // streaming, one per cycle
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(v0), 32'd1);
      check("stream_pc", pc0, 32'(4 * k));
      check("stream_instr", ins0, instr_of(32'(4 * k)));
      check("stream_count", 32'(cnt0), 32'd1);
    end

    // stall: fills to 2, then holds
    rdy0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("stall_count", 32'(cnt0), 32'd2);
      check("stall_addr", addr0, 32'd24);
      check("stall_pc", pc0, 32'd16);
    end

    // full with pop: one in, one out per cycle
    rdy0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("full_pc", pc0, 32'(16 + 4 * k));
      check("full_instr", ins0, instr_of(32'(16 + 4 * k)));
      check("full_count", 32'(cnt0), 32'd2);
      check("full_addr", addr0, 32'(24 + 4 * k));
    end

    // redirect with queue full
    rdy0 = 1'b0;
    rv0  = 1'b1;
    rpc0 = 32'h43;
    @(negedge clk);
    rv0  = 1'b0;
    rpc0 = '0;
    check("redir_valid", 32'(v0), 32'd0);
    check("redir_count", 32'(cnt0), 32'd0);
    check("redir_addr", addr0, 32'h40);
    @(negedge clk);
    check("tgt_valid", 32'(v0), 32'd1);
    check("tgt_pc", pc0, 32'h40);
    check("tgt_instr", ins0, instr_of(32'h40));
    check("tgt_count", 32'(cnt0), 32'd1);
    check("tgt_addr", addr0, 32'h44);

    // wrap from top-of-space reset PC
    check("wrap_rst_addr", addr1, 32'hFFFF_FFFC);
    check("wrap_rst_valid", 32'(v1), 32'd0);
    rst1 = 1'b1;
    @(negedge clk);
    check("wrap_pc0", pc1, 32'hFFFF_FFFC);
    check("wrap_instr0", ins1, instr_of(32'hFFFF_FFFC));
    check("wrap_addr0", addr1, 32'h0);
    @(negedge clk);
    check("wrap_pc1", pc1, 32'h0);
    check("wrap_instr1", ins1, instr_of(32'h0));
    @(negedge clk);
    check("wrap_pc2", pc1, 32'h4);

    // asynchronous reset mid-cycle
    #5;
    rst1 = 1'b0;
    #1;
    check("async_valid", 32'(v1), 32'd0);
    check("async_addr", addr1, 32'hFFFF_FFFC);
    check("async_count", 32'(cnt1), 32'd0);
    check("async_idpc", pc1, 32'h0);
    @(negedge clk);
    check("async_hold", addr1, 32'hFFFF_FFFC);
    rst1 = 1'b1;
    @(negedge clk);
    check("async_rel_pc", pc1, 32'hFFFF_FFFC);
    check("async_rel_valid", 32'(v1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
